r16_output_drain: RTL and testbench
===================================

Name: r16_output_drain

Overview:
Output-side counterpart to the radix-16 input alignment stage. It accepts one 16-lane result frame per handshake from the radix-16 PE and buffers up to DEPTH frames. Each frame is drained to downstream logic as BEATS = 16/OUT_LANES narrower beats under a valid/ready handshake. Backpressure is returned to the PE through in_ready.

Parameters:
D_WIDTH, 64, width of one lane sample
OUT_LANES, 4, lanes per output beat; legal values 1, 2, 4, 8, 16 (elaboration error otherwise)
DEPTH, 2, frame buffer capacity in frames; minimum 1

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  PE presents a frame
in_ready  output  1  block can accept a frame
in_data  input  16*D_WIDTH  lane k at bits [k*D_WIDTH +: D_WIDTH]
out_valid  output  1  beat available
out_ready  input  1  downstream accepts beat
out_data  output  OUT_LANES*D_WIDTH  local lane j = frame lane beat*OUT_LANES+j
out_beat  output  max(1,clog2(BEATS))  index of current beat within frame
out_last  output  1  current beat is the final beat of its frame
occupancy  output  clog2(DEPTH+1)  frames stored, including the partially drained one

Behaviour:
- Reset is decided as follows: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: storage all 0; write pointer, read pointer, beat counter and occupancy 0; out_valid 0, out_last 0, out_data 0; in_ready 1.
- Push: in_valid && in_ready. The frame is written at the write pointer, the pointer advances modulo DEPTH and occupancy increments.
- in_ready = (occupancy < DEPTH). It depends only on registered state, never on out_ready. There is no bypass: when the buffer is full, a pop in the same cycle does not open in_ready.
- out_valid = (occupancy > 0). A frame pushed at edge t gives out_valid at t+1, so latency is 1 cycle minimum.
- out_data and out_beat are driven combinationally from the head frame and the beat counter.
- out_last = out_valid && (beat == BEATS-1).
- Pop beat: out_valid && out_ready.
  - beat < BEATS-1: beat increments.
  - beat == BEATS-1: beat returns to 0, the read pointer advances modulo DEPTH and occupancy decrements.
- While out_valid && !out_ready, out_data, out_beat and out_last are held stable.
- Push and a final-beat pop in the same cycle leave occupancy unchanged. Both pointers advance.
- Pointer wrap: DEPTH-1 -> 0. The design must not require DEPTH to be a power of 2.
- Reset asserted mid-frame discards all frames and any partial drain. The next frame starts at beat 0.
- Throughput:
  - Sustained rate is 1 frame per BEATS cycles when out_ready is held high.
  - With OUT_LANES=16 and DEPTH≥2, the rate is 1 frame per cycle.
- X on in_data while in_valid=0 must not propagate into storage.

Decomposition:
- Shared package r16_pkg:
  - R16_LANES = 16
  - D_WIDTH default 64, the same value used by the existing R16 datapath
  - a lane-slice helper function
  - a derived BEATS/beat-width computation
- Sub-module r16_frame_fifo: DEPTH x 16*D_WIDTH storage, write/read pointers, occupancy and full/empty flags.
- The top level holds only the beat counter, the beat mux and the out_last logic.

Test Plan:
1. Reset (defaults): hold rst_n=0, then release -> out_valid=0, in_ready=1, occupancy=0, out_data=0.
2. Single frame (OUT_LANES=4, lane k = k+1, out_ready=1) -> out_valid rises 1 cycle after accept; beats are {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,16}; out_last on beat 3 only; occupancy ends at 0.
3. Backpressure (out_ready=0, push 3 frames back-to-back) -> in_ready=0 after the 2nd accept and occupancy=2; the 3rd frame is held by the source; out_data stays constant; raising out_ready drains 8 beats in order, with the 3rd frame accepted after the first frame's last beat.
4. Simultaneous push and pop: occupancy=1, push on the same edge as the final-beat pop -> occupancy stays 1, next beat 0 shows the new frame's lanes 0–3.
5. Reset mid-frame: assert rst_n low at beat 2 of a frame with 2 frames stored -> all outputs at reset values; a fresh frame after release drains from beat 0.
6. OUT_LANES=16, DEPTH=2, in_valid and out_ready continuously 1, 10 frames -> one frame per cycle, out_last=out_valid every cycle, in_ready never drops, order preserved.

Source files
------------

// File: rtl/r16_pkg.sv
// Shared constants and helpers for the radix-16 datapath: lane geometry and
// the beat arithmetic used when a 16-lane frame is split into narrower beats.
package r16_pkg;

  localparam int unsigned R16_LANES   = 16;
  localparam int unsigned R16_D_WIDTH = 64;

  function automatic int unsigned r16_beats(input int unsigned out_lanes);
    return R16_LANES / out_lanes;
  endfunction

  // Beat index width; a single-beat frame still carries a 1-bit index.
  function automatic int unsigned r16_beat_w(input int unsigned out_lanes);
    return (R16_LANES / out_lanes > 1) ? $clog2(R16_LANES / out_lanes) : 1;
  endfunction

  function automatic logic [R16_D_WIDTH-1:0] r16_lane(
    input logic [R16_LANES*R16_D_WIDTH-1:0] frame,
    input int unsigned                      k
  );
    return frame[k*R16_D_WIDTH +: R16_D_WIDTH];
  endfunction

endpackage

// File: rtl/r16_frame_fifo.sv
// Frame buffer: DEPTH full-width frames with wrap-around pointers that do not
// assume a power-of-two depth.
module r16_frame_fifo
  import r16_pkg::*;
#(
  parameter int unsigned WIDTH = R16_LANES * R16_D_WIDTH,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (push_i && !pop_i)      count_d = count_q + 1'b1;
    else if (!push_i && pop_i) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Storage is only written on an accepted push, so idle-bus X never lands.
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/r16_output_drain.sv
// Drains buffered 16-lane PE result frames as BEATS narrower beats over a
// valid/ready link; in_ready reflects buffer space only (no pop bypass).
module r16_output_drain
  import r16_pkg::*;
#(
  parameter int unsigned D_WIDTH   = R16_D_WIDTH,
  parameter int unsigned OUT_LANES = 4,
  parameter int unsigned DEPTH     = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [R16_LANES*D_WIDTH-1:0]        in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUT_LANES*D_WIDTH-1:0]        out_data,
  output logic [r16_beat_w(OUT_LANES)-1:0]    out_beat,
  output logic                                out_last,
  output logic [$clog2(DEPTH+1)-1:0]          occupancy
);

  localparam int unsigned BEATS  = r16_beats(OUT_LANES);
  localparam int unsigned BW     = r16_beat_w(OUT_LANES);
  localparam int unsigned BEAT_W = OUT_LANES * D_WIDTH;

  if (!(OUT_LANES == 1 || OUT_LANES == 2 || OUT_LANES == 4 ||
        OUT_LANES == 8 || OUT_LANES == 16)) begin : g_bad_lanes
    $error("r16_output_drain: OUT_LANES must be 1, 2, 4, 8 or 16");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("r16_output_drain: DEPTH must be at least 1");
  end

  logic [R16_LANES*D_WIDTH-1:0] head;
  logic                         full, empty;
  logic                         push, beat_pop, frame_pop, beat_last;
  logic [BW-1:0]                beat_q, beat_d;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign beat_last = (beat_q == BW'(BEATS - 1));
  assign beat_pop  = out_valid && out_ready;
  assign frame_pop = beat_pop && beat_last;

  r16_frame_fifo #(
    .WIDTH (R16_LANES * D_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (frame_pop),
    .wdata_i (in_data),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (occupancy)
  );

  always_comb begin
    beat_d = beat_q;
    if (beat_pop) beat_d = beat_last ? '0 : beat_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_q <= '0;
    else        beat_q <= beat_d;
  end

  always_comb begin
    out_data = '0;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (beat_q == BW'(b)) out_data = head[b*BEAT_W +: BEAT_W];
    end
  end

  assign out_beat = beat_q;
  assign out_last = out_valid && beat_last;

endmodule

// File: tb/tb_r16_output_drain.sv
// Directed plus randomized bench for r16_output_drain, checked against a
// frame-queue reference model (4-lane/depth-2 and 16-lane/depth-2 instances).
module tb_r16_output_drain;

  localparam int unsigned DW    = 64;
  localparam int unsigned OL    = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned BEATS = 16 / OL;
  localparam int unsigned FW    = 16 * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, out_ready;
  logic [FW-1:0] in_data;
  logic          in_ready, out_valid, out_last;
  logic [OL*DW-1:0] out_data;
  logic [1:0]    out_beat;
  logic [1:0]    occupancy;

  logic          in_valid16, out_ready16;
  logic [FW-1:0] in_data16;
  logic          in_ready16, out_valid16, out_last16;
  logic [FW-1:0] out_data16;
  logic [0:0]    out_beat16;
  logic [1:0]    occupancy16;

  int checks   = 0;
  int failures = 0;

  logic [FW-1:0] mq[$];
  logic [FW-1:0] mq16[$];
  int            mbeat     = 0;
  logic          last_push = 1'b0;

  always #5 clk = ~clk;

  r16_output_drain #(.D_WIDTH(DW), .OUT_LANES(OL), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_beat(out_beat), .out_last(out_last),
    .occupancy(occupancy)
  );

  r16_output_drain #(.D_WIDTH(DW), .OUT_LANES(16), .DEPTH(2)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_data(in_data16), .out_valid(out_valid16), .out_ready(out_ready16),
    .out_data(out_data16), .out_beat(out_beat16), .out_last(out_last16),
    .occupancy(occupancy16)
  );

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int i = 0; i < FW / 32; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  function automatic logic [OL*DW-1:0] count_beat(input int k);
    logic [OL*DW-1:0] e;
    for (int j = 0; j < OL; j++) e[j*DW +: DW] = DW'(k * OL + j + 1);
    return e;
  endfunction

  task automatic check_model();
    chk("in_ready",  in_ready,  mq.size() < DEPTH);
    chk("out_valid", out_valid, mq.size() > 0);
    chk("occupancy", occupancy, mq.size());
    chk("out_last",  out_last,  (mq.size() > 0) && (mbeat == BEATS - 1));
    if (mq.size() > 0) begin
      chk("out_beat", out_beat, mbeat);
      chk("out_data", out_data, mq[0][mbeat*OL*DW +: OL*DW]);
    end
    chk("in_ready16",  in_ready16,  mq16.size() < 2);
    chk("out_valid16", out_valid16, mq16.size() > 0);
    chk("out_last16",  out_last16,  mq16.size() > 0);
    chk("occupancy16", occupancy16, mq16.size());
    if (mq16.size() > 0) chk("out_data16", out_data16, mq16[0]);
  endtask

  // One clock: compare at negedge, then apply the handshake rules at posedge.
  task automatic tick();
    logic push, pop, push16, pop16;
    @(negedge clk);
    check_model();
    push   = rst_n && in_valid && (mq.size() < DEPTH);
    pop    = rst_n && out_ready && (mq.size() > 0);
    push16 = rst_n && in_valid16 && (mq16.size() < 2);
    pop16  = rst_n && out_ready16 && (mq16.size() > 0);
    @(posedge clk);
    if (pop) begin
      if (mbeat == BEATS - 1) begin
        void'(mq.pop_front());
        mbeat = 0;
      end else mbeat++;
    end
    if (push) mq.push_back(in_data);
    if (pop16) void'(mq16.pop_front());
    if (push16) mq16.push_back(in_data16);
    last_push = push;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_valid16 = 1'b0; out_ready16 = 1'b0;
    mq.delete(); mq16.delete(); mbeat = 0;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_occupancy", occupancy, 2'd0);
    chk("rst_out_data",  out_data,  '0);
    chk("rst_out_last",  out_last,  1'b0);
    chk("rst_out_beat",  out_beat,  2'd0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [FW-1:0] f;
    logic [FW-1:0] fa, fb;
    rst_n = 1'b0;
    in_data = '0; in_data16 = '0;
    in_valid = 1'b0; out_ready = 1'b0; in_valid16 = 1'b0; out_ready16 = 1'b0;

    // 1: reset defaults
    #3;
    do_reset();
    tick();

    // 2: single counting frame, out_ready high
    for (int k = 0; k < 16; k++) f[k*DW +: DW] = DW'(k + 1);
    in_data = f; in_valid = 1'b1; out_ready = 1'b1;
    chk("t2_idle_valid", out_valid, 1'b0);
    tick();
    in_valid = 1'b0; in_data = '0;
    chk("t2_latency_valid", out_valid, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("t2_beat_data", out_data, count_beat(k));
      chk("t2_beat_last", out_last, k == 3);
      tick();
    end
    chk("t2_occ_end", occupancy, 2'd0);

    // 3: backpressure with three frames, source holds the third
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = rand_frame(); tick();
    in_data = rand_frame(); tick();
    in_data = rand_frame();
    chk("t3_full_ready", in_ready, 1'b0);
    chk("t3_full_occ", occupancy, 2'd2);
    f = out_data;
    tick(); tick();
    chk("t3_hold_data", out_data, f);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (last_push) in_valid = 1'b0;
    end
    chk("t3_drained", occupancy, 2'd0);

    // 4: push coincides with the final-beat pop at occupancy 1
    fa = rand_frame(); fb = rand_frame();
    in_data = fa; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    chk("t4_last_beat", out_last, 1'b1);
    in_data = fb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t4_occ_kept", occupancy, 2'd1);
    chk("t4_beat0", out_beat, 2'd0);
    chk("t4_new_lanes", out_data, fb[OL*DW-1:0]);
    out_ready = 1'b1;
    repeat (5) tick();

    // 5: reset mid-frame with two frames stored
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = rand_frame(); tick();
    in_data = rand_frame(); tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("t5_at_beat2", out_beat, 2'd2);
    do_reset();
    fa = rand_frame();
    in_data = fa; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t5_fresh_beat0", out_beat, 2'd0);
    chk("t5_fresh_data", out_data, fa[OL*DW-1:0]);
    repeat (5) tick();

    // 6: 16-lane instance streaming one frame per cycle
    in_valid16 = 1'b1; out_ready16 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data16 = rand_frame();
      chk("t6_in_ready", in_ready16, 1'b1);
      if (i > 0) chk("t6_last_eq_valid", out_last16, out_valid16);
      if (i > 0) chk("t6_valid", out_valid16, 1'b1);
      tick();
    end
    in_valid16 = 1'b0;
    repeat (3) tick();
    out_ready16 = 1'b0;

    // randomized traffic on the 4-lane instance
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || last_push) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = rand_frame();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) tick();
    chk("final_empty", occupancy, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
